// File: rtl/motor_pwm_ctrl_pkg.sv
// Shared definitions for the motor PWM controller: channel state encodings,
// default parameter values and the duty ramp helper.
package motor_pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COOL    = 2'd2,
    ST_LOCKOUT = 2'd3
  } ch_state_e;

  localparam int DEF_NUM_CH       = 2;
  localparam int DEF_PWM_W        = 8;
  localparam int DEF_CLK_DIV      = 390;
  localparam int DEF_RAMP_STEP    = 4;
  localparam int DEF_RAMP_DIV     = 2;
  localparam int DEF_OC_FILTER    = 16;
  localparam int DEF_OC_COOLDOWN  = 500;
  localparam int DEF_OC_MAX_RETRY = 3;

  // Move cur toward tgt by at most step, never overshooting.
  function automatic int unsigned ramp_toward(input int unsigned cur,
                                              input int unsigned tgt,
                                              input int unsigned step);
    if (tgt > cur) return ((tgt - cur) > step) ? (cur + step) : tgt;
    else           return ((cur - tgt) > step) ? (cur - step) : tgt;
  endfunction

endpackage

// File: rtl/motor_pwm_ctrl_channel.sv
// One motor channel: overcurrent synchroniser/filter, run/cool/lockout FSM,
// retry and cooldown bookkeeping, duty ramp and PWM compare.
module motor_pwm_ctrl_channel
  import motor_pwm_ctrl_pkg::*;
#(
  parameter int PWM_W        = DEF_PWM_W,
  parameter int RAMP_STEP    = DEF_RAMP_STEP,
  parameter int OC_FILTER    = DEF_OC_FILTER,
  parameter int OC_COOLDOWN  = DEF_OC_COOLDOWN,
  parameter int OC_MAX_RETRY = DEF_OC_MAX_RETRY
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_estop,
  input  logic [PWM_W-1:0] i_duty_target,
  input  logic             i_oc,
  input  logic             i_oc_clear,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic             i_wrap,
  input  logic             i_ramp,
  output logic             o_pwm,
  output logic [PWM_W-1:0] o_duty_now,
  output logic             o_oc_fault,
  output logic             o_oc_lockout
);

  localparam int FL_W = $clog2(OC_FILTER + 1);
  localparam int CD_W = (OC_COOLDOWN > 1) ? $clog2(OC_COOLDOWN) : 1;
  localparam int RT_W = $clog2(OC_MAX_RETRY + 1);

  ch_state_e        r_state, w_nstate;
  logic [1:0]       r_sync;
  logic [FL_W-1:0]  r_filt;
  logic [CD_W-1:0]  r_cool;
  logic [RT_W-1:0]  r_retry;
  logic [PWM_W-1:0] r_duty;
  logic             r_pwm;

  logic w_oc_qual;
  logic w_cool_done;

  // Qualifies on the OC_FILTER-th consecutive high sample, so the trip lands
  // 2 + OC_FILTER clocks after the raw input rises.
  assign w_oc_qual   = (r_state == ST_RUN) && r_sync[1] &&
                       (r_filt >= FL_W'(OC_FILTER - 1));
  assign w_cool_done = (r_cool == CD_W'(OC_COOLDOWN - 1));

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      ST_IDLE: if (i_enable && !i_estop) w_nstate = ST_RUN;
      ST_RUN: begin
        if (w_oc_qual)                 w_nstate = ST_COOL;
        else if (!i_enable || i_estop) w_nstate = ST_IDLE;
      end
      ST_COOL: begin
        if (i_oc_clear)                w_nstate = ST_IDLE;
        else if (i_wrap && w_cool_done)
          w_nstate = (r_retry == RT_W'(OC_MAX_RETRY)) ? ST_LOCKOUT : ST_IDLE;
      end
      ST_LOCKOUT: if (i_oc_clear) w_nstate = ST_IDLE;
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_sync  <= '0;
      r_filt  <= '0;
      r_cool  <= '0;
      r_retry <= '0;
      r_duty  <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_sync  <= {r_sync[0], i_oc};

      if (r_state == ST_RUN && r_sync[1]) begin
        if (r_filt != FL_W'(OC_FILTER)) r_filt <= r_filt + FL_W'(1);
      end else begin
        r_filt <= '0;
      end

      if (r_state != ST_COOL)            r_cool <= '0;
      else if (i_wrap && !w_cool_done)   r_cool <= r_cool + CD_W'(1);

      // A trip coinciding with oc_clear counts as the first trip after the clear.
      if (r_state == ST_RUN && w_nstate == ST_COOL)
        r_retry <= (i_oc_clear ? RT_W'(0) : r_retry) + RT_W'(1);
      else if (i_oc_clear)
        r_retry <= '0;

      if (w_nstate != ST_RUN)
        r_duty <= '0;
      else if (r_state == ST_RUN && i_ramp)
        r_duty <= PWM_W'(ramp_toward(32'(r_duty), 32'(i_duty_target), RAMP_STEP));

      // Compare against the next state so a drop out of RUN silences the
      // output on the very next clock.
      r_pwm <= (w_nstate == ST_RUN) && (i_cnt < r_duty);
    end
  end

  assign o_pwm        = r_pwm;
  assign o_duty_now   = r_duty;
  assign o_oc_fault   = (r_state == ST_COOL) || (r_state == ST_LOCKOUT);
  assign o_oc_lockout = (r_state == ST_LOCKOUT);

endmodule

// File: rtl/motor_pwm_ctrl.sv
// N-channel motor PWM generator: shared prescaler, PWM counter, period pulse
// and ramp divider feeding one channel instance per motor.
module motor_pwm_ctrl
  import motor_pwm_ctrl_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int PWM_W        = DEF_PWM_W,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int RAMP_STEP    = DEF_RAMP_STEP,
  parameter int RAMP_DIV     = DEF_RAMP_DIV,
  parameter int OC_FILTER    = DEF_OC_FILTER,
  parameter int OC_COOLDOWN  = DEF_OC_COOLDOWN,
  parameter int OC_MAX_RETRY = DEF_OC_MAX_RETRY
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    estop,
  input  logic [NUM_CH*PWM_W-1:0] duty_target,
  input  logic [NUM_CH-1:0]       oc_in,
  input  logic                    oc_clear,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH*PWM_W-1:0] duty_now,
  output logic [NUM_CH-1:0]       oc_fault,
  output logic [NUM_CH-1:0]       oc_lockout,
  output logic                    period_start
);

  localparam int PRE_W = (CLK_DIV > 1)  ? $clog2(CLK_DIV)  : 1;
  localparam int RD_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [PRE_W-1:0] r_presc;
  logic [PWM_W-1:0] r_cnt;
  logic [RD_W-1:0]  r_rdiv;
  logic             r_period_start;

  logic w_tick;
  logic w_wrap;
  logic w_ramp;

  assign w_tick = (r_presc == PRE_W'(CLK_DIV - 1));
  assign w_wrap = w_tick && (r_cnt == '1);
  // Channels update duty on the same edge the counter wraps, so each period
  // is compared against a single duty value.
  assign w_ramp = w_wrap && (r_rdiv == RD_W'(RAMP_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc        <= '0;
      r_cnt          <= '0;
      r_rdiv         <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_presc        <= w_tick ? '0 : r_presc + PRE_W'(1);
      r_period_start <= w_wrap;
      if (w_tick) r_cnt <= r_cnt + PWM_W'(1);
      if (w_wrap) r_rdiv <= w_ramp ? '0 : r_rdiv + RD_W'(1);
    end
  end

  assign period_start = r_period_start;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    motor_pwm_ctrl_channel #(
      .PWM_W        (PWM_W),
      .RAMP_STEP    (RAMP_STEP),
      .OC_FILTER    (OC_FILTER),
      .OC_COOLDOWN  (OC_COOLDOWN),
      .OC_MAX_RETRY (OC_MAX_RETRY)
    ) u_ch (
      .i_clk         (clock),
      .i_rst_n       (reset_n),
      .i_enable      (enable),
      .i_estop       (estop),
      .i_duty_target (duty_target[g*PWM_W +: PWM_W]),
      .i_oc          (oc_in[g]),
      .i_oc_clear    (oc_clear),
      .i_cnt         (r_cnt),
      .i_wrap        (w_wrap),
      .i_ramp        (w_ramp),
      .o_pwm         (pwm_out[g]),
      .o_duty_now    (duty_now[g*PWM_W +: PWM_W]),
      .o_oc_fault    (oc_fault[g]),
      .o_oc_lockout  (oc_lockout[g])
    );
  end

endmodule
